// File: rtl/xillybus_lite_regbank_pkg.sv
// Shared constants for the Xillybus Lite register bank: register offsets,
// pending-bit indices, default ID word and a byte-strobe expansion helper.
package xlregbank_pkg;

  localparam logic [31:0] ID_VALUE_DEF = 32'h4D5A5449;

  localparam logic [6:0] OFS_ID       = 7'h00;
  localparam logic [6:0] OFS_SCRATCH  = 7'h04;
  localparam logic [6:0] OFS_CTRL     = 7'h08;
  localparam logic [6:0] OFS_STATUS   = 7'h0C;
  localparam logic [6:0] OFS_IRQ_PEND = 7'h10;
  localparam logic [6:0] OFS_IRQ_MASK = 7'h14;
  localparam logic [6:0] OFS_EVT_DATA = 7'h18;
  localparam logic [6:0] OFS_EVT_STAT = 7'h1C;

  localparam int PEND_OVF = 30;
  localparam int PEND_NE  = 31;

  // Word index as seen on user_addr[6:2]
  typedef enum logic [4:0] {
    REG_ID       = OFS_ID[6:2],
    REG_SCRATCH  = OFS_SCRATCH[6:2],
    REG_CTRL     = OFS_CTRL[6:2],
    REG_STATUS   = OFS_STATUS[6:2],
    REG_IRQ_PEND = OFS_IRQ_PEND[6:2],
    REG_IRQ_MASK = OFS_IRQ_MASK[6:2],
    REG_EVT_DATA = OFS_EVT_DATA[6:2],
    REG_EVT_STAT = OFS_EVT_STAT[6:2]
  } reg_idx_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/xillybus_lite_regbank_evt_fifo.sv
// Single-clock event FIFO with occupancy count and an overflow pulse that
// fires when a push is dropped because the FIFO is full and not popping.
module xlregbank_evt_fifo #(
  parameter int AW = 4,
  parameter int W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf
);
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push at full still lands
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~do_pop;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/xillybus_lite_regbank.sv
// Xillybus Lite register bank with masked edge interrupts and an optional
// event FIFO (enabled by defining XLREGBANK_EVT_FIFO_EN).
module xillybus_lite_regbank
  import xlregbank_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEF,
  parameter int          IRQ_W    = 8,
  parameter int          FIFO_AW  = 4,
  parameter int          EVT_W    = 16
) (
  input  logic             user_clk,
  input  logic             bus_rst_n,
  input  logic             user_wren,
  input  logic [3:0]       user_wstrb,
  input  logic             user_rden,
  input  logic [31:0]      user_addr,
  input  logic [31:0]      user_wr_data,
  output logic [31:0]      user_rd_data,
  output logic             user_irq,
  output logic [31:0]      ctrl_o,
  input  logic [31:0]      status_i,
  input  logic [IRQ_W-1:0] irq_src_i,
  input  logic             evt_valid_i,
  input  logic [EVT_W-1:0] evt_data_i
);
  localparam logic [31:0] SRC_BITS = {{(32-IRQ_W){1'b0}}, {IRQ_W{1'b1}}};
`ifdef XLREGBANK_EVT_FIFO_EN
  localparam logic [31:0] PEND_BITS = SRC_BITS | (32'd1 << PEND_OVF);
  localparam logic [31:0] MASK_BITS = PEND_BITS | (32'd1 << PEND_NE);
`else
  localparam logic [31:0] PEND_BITS = SRC_BITS;
  localparam logic [31:0] MASK_BITS = SRC_BITS;
`endif

  logic [4:0]       word;
  logic [31:0]      wmask;
  logic             rd_en;
  logic             unused_addr;

  logic [31:0]      scratch_reg, scratch_next;
  logic [31:0]      ctrl_reg, ctrl_next;
  logic [31:0]      status_reg;
  logic [31:0]      pend_reg, pend_next;
  logic [31:0]      mask_reg, mask_next;
  logic [IRQ_W-1:0] src_reg, src_prev_reg;
  logic [31:0]      rd_data_reg, rd_data_next;
  logic             irq_reg;

  logic [31:0]      pend_view;
  logic [31:0]      pend_clr;
  logic [31:0]      pend_set;
  logic             ovf_set;
  logic             pend_ne;
  logic [31:0]      evt_head_word;
  logic [31:0]      evt_stat_word;

  assign word        = user_addr[6:2];
  assign wmask       = byte_mask(user_wstrb);
  assign rd_en       = user_rden & ~user_wren;
  assign unused_addr = ^{user_addr[31:7], user_addr[1:0]};

`ifdef XLREGBANK_EVT_FIFO_EN
  logic             fifo_pop;
  logic             fifo_full_unused;
  logic             fifo_empty;
  logic             fifo_ovf;
  logic [EVT_W-1:0] fifo_head;
  logic [FIFO_AW:0] fifo_count;
  logic             evt_ovf_reg, evt_ovf_next;

  assign fifo_pop = rd_en & (word == REG_EVT_DATA);

  xlregbank_evt_fifo #(
    .AW (FIFO_AW),
    .W  (EVT_W)
  ) u_evt_fifo (
    .clk       (user_clk),
    .rst_n     (bus_rst_n),
    .push      (evt_valid_i),
    .push_data (evt_data_i),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .ovf       (fifo_ovf)
  );

  // A drop in the same cycle as the clear leaves the sticky bit set
  always_comb begin
    evt_ovf_next = evt_ovf_reg;
    if (user_wren && (word == REG_EVT_STAT) && user_wstrb[3] && user_wr_data[31])
      evt_ovf_next = 1'b0;
    if (fifo_ovf)
      evt_ovf_next = 1'b1;
  end

  always_ff @(posedge user_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) evt_ovf_reg <= 1'b0;
    else            evt_ovf_reg <= evt_ovf_next;
  end

  assign ovf_set = fifo_ovf;
  assign pend_ne = ~fifo_empty;

  always_comb begin
    evt_head_word = '0;
    if (!fifo_empty) evt_head_word[EVT_W-1:0] = fifo_head;
    evt_stat_word = '0;
    evt_stat_word[FIFO_AW:0] = fifo_count;
    evt_stat_word[31] = evt_ovf_reg;
  end
`else
  logic unused_evt;
  assign unused_evt    = ^{evt_valid_i, evt_data_i};
  assign ovf_set       = 1'b0;
  assign pend_ne       = 1'b0;
  assign evt_head_word = '0;
  assign evt_stat_word = '0;
`endif

  always_comb begin
    scratch_next = scratch_reg;
    ctrl_next    = ctrl_reg;
    mask_next    = mask_reg;
    pend_clr     = '0;
    if (user_wren) begin
      case (word)
        REG_SCRATCH:  scratch_next = (scratch_reg & ~wmask) | (user_wr_data & wmask);
        REG_CTRL:     ctrl_next    = (ctrl_reg & ~wmask) | (user_wr_data & wmask);
        REG_IRQ_MASK: mask_next    = ((mask_reg & ~wmask) | (user_wr_data & wmask)) & MASK_BITS;
        REG_IRQ_PEND: pend_clr     = user_wr_data & wmask;
        default:      ;
      endcase
    end
    // New edges are OR-ed in after the W1C so a same-cycle set survives
    pend_set           = 32'(src_reg & ~src_prev_reg);
    pend_set[PEND_OVF] = ovf_set;
    pend_next          = ((pend_reg & ~pend_clr) | pend_set) & PEND_BITS;
    pend_view          = pend_reg;
    pend_view[PEND_NE] = pend_ne;
  end

  always_comb begin
    rd_data_next = rd_data_reg;
    if (user_rden) begin
      rd_data_next = '0;
      if (rd_en) begin
        case (word)
          REG_ID:       rd_data_next = ID_VALUE;
          REG_SCRATCH:  rd_data_next = scratch_reg;
          REG_CTRL:     rd_data_next = ctrl_reg;
          REG_STATUS:   rd_data_next = status_reg;
          REG_IRQ_PEND: rd_data_next = pend_view;
          REG_IRQ_MASK: rd_data_next = mask_reg;
          REG_EVT_DATA: rd_data_next = evt_head_word;
          REG_EVT_STAT: rd_data_next = evt_stat_word;
          default:      rd_data_next = '0;
        endcase
      end
    end
  end

  always_ff @(posedge user_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      scratch_reg  <= '0;
      ctrl_reg     <= '0;
      status_reg   <= '0;
      pend_reg     <= '0;
      mask_reg     <= '0;
      src_reg      <= '0;
      src_prev_reg <= '0;
      rd_data_reg  <= '0;
      irq_reg      <= 1'b0;
    end else begin
      scratch_reg  <= scratch_next;
      ctrl_reg     <= ctrl_next;
      status_reg   <= status_i;
      pend_reg     <= pend_next;
      mask_reg     <= mask_next;
      src_reg      <= irq_src_i;
      src_prev_reg <= src_reg;
      rd_data_reg  <= rd_data_next;
      irq_reg      <= |(pend_view & mask_reg);
    end
  end

  assign user_rd_data = rd_data_reg;
  assign user_irq     = irq_reg;
  assign ctrl_o       = ctrl_reg;

endmodule

// File: tb/tb_xillybus_lite_regbank.sv
// Directed and randomized checks of the register bank against a small
// register-level model; FIFO scenarios run when XLREGBANK_EVT_FIFO_EN is set.
module tb_xillybus_lite_regbank;
  localparam int IRQ_W   = 8;
  localparam int FIFO_AW = 4;
  localparam int EVT_W   = 16;
  localparam logic [31:0] ID = 32'h4D5A5449;
`ifdef XLREGBANK_EVT_FIFO_EN
  localparam logic [31:0] VALID = 32'hC00000FF;
`else
  localparam logic [31:0] VALID = 32'h000000FF;
`endif

  logic             user_clk = 1'b0;
  logic             bus_rst_n = 1'b1;
  logic             user_wren = 1'b0;
  logic [3:0]       user_wstrb = '0;
  logic             user_rden = 1'b0;
  logic [31:0]      user_addr = '0;
  logic [31:0]      user_wr_data = '0;
  logic [31:0]      user_rd_data;
  logic             user_irq;
  logic [31:0]      ctrl_o;
  logic [31:0]      status_i = '0;
  logic [IRQ_W-1:0] irq_src_i = '0;
  logic             evt_valid_i = 1'b0;
  logic [EVT_W-1:0] evt_data_i = '0;

  int errors = 0;
  int checks = 0;

  logic [31:0]      scratch_m, ctrl_m, mask_m, pend_m;
  logic [IRQ_W-1:0] prev_src;
  logic [31:0]      rdv, d, a, st;
  logic [3:0]       s;
  logic [EVT_W-1:0] w;
  logic [EVT_W-1:0] q[$];

  always #5 user_clk = ~user_clk;

  xillybus_lite_regbank #(
    .ID_VALUE (ID),
    .IRQ_W    (IRQ_W),
    .FIFO_AW  (FIFO_AW),
    .EVT_W    (EVT_W)
  ) dut (
    .user_clk     (user_clk),
    .bus_rst_n    (bus_rst_n),
    .user_wren    (user_wren),
    .user_wstrb   (user_wstrb),
    .user_rden    (user_rden),
    .user_addr    (user_addr),
    .user_wr_data (user_wr_data),
    .user_rd_data (user_rd_data),
    .user_irq     (user_irq),
    .ctrl_o       (ctrl_o),
    .status_i     (status_i),
    .irq_src_i    (irq_src_i),
    .evt_valid_i  (evt_valid_i),
    .evt_data_i   (evt_data_i)
  );

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("chk %-14s observed=%h expected=%h", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bm(input logic [3:0] sb);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (sb[i]) r[i*8 +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic wr(input logic [31:0] ad, input logic [31:0] dt, input logic [3:0] sb);
    user_addr = ad; user_wr_data = dt; user_wstrb = sb; user_wren = 1'b1;
    tick();
    user_wren = 1'b0; user_wstrb = '0;
  endtask

  task automatic rd(input logic [31:0] ad, output logic [31:0] dt);
    user_addr = ad; user_rden = 1'b1;
    tick();
    user_rden = 1'b0;
    dt = user_rd_data;
  endtask

  // Spec rule: a 0->1 change of a source between consecutive cycles sets its bit
  task automatic drive_src(input logic [IRQ_W-1:0] v);
    pend_m = pend_m | 32'(v & ~prev_src);
    prev_src = v;
    irq_src_i = v;
  endtask

  initial begin
    scratch_m = '0; ctrl_m = '0; mask_m = '0; pend_m = '0; prev_src = '0;
    #2 bus_rst_n = 1'b0;
    tick(); tick();
    check("rst_rd_data", user_rd_data, 32'h0);
    check("rst_irq", 32'(user_irq), 32'h0);
    check("rst_ctrl", ctrl_o, 32'h0);
    bus_rst_n = 1'b1;
    tick();
    check("pre_rd_data", user_rd_data, 32'h0);
    rd(32'h00, rdv); check("id_read", rdv, ID);

    wr(32'h08, 32'hA5A5A5A5, 4'b0101);
    ctrl_m = 32'h00A500A5;
    check("ctrl_o_strb", ctrl_o, 32'h00A500A5);
    rd(32'h08, rdv); check("ctrl_readback", rdv, ctrl_m);

    for (int i = 0; i < 6; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 32'h04 : 32'h08;
      d = $urandom; s = 4'($urandom_range(0, 15));
      wr(a, d, s);
      if (a == 32'h04) scratch_m = (scratch_m & ~bm(s)) | (d & bm(s));
      else             ctrl_m    = (ctrl_m & ~bm(s)) | (d & bm(s));
      rd(a, rdv);
      check(a == 32'h04 ? "rand_scratch" : "rand_ctrl", rdv, a == 32'h04 ? scratch_m : ctrl_m);
    end
    check("ctrl_o_rand", ctrl_o, ctrl_m);

    st = $urandom; status_i = st;
    tick(); tick();
    rd(32'h0C, rdv); check("status_read", rdv, st);
    status_i = ~st;
    tick(); tick(); tick();
    check("rd_data_hold", user_rd_data, st);

    wr(32'h20, $urandom, 4'hF);
    rd(32'h20, rdv); check("unmapped_20", rdv, 32'h0);
    rd(32'h7C, rdv); check("unmapped_7c", rdv, 32'h0);
    rd(32'h80, rdv); check("alias_id", rdv, ID);

    d = $urandom;
    user_addr = 32'h04; user_wr_data = d; user_wstrb = 4'hF;
    user_wren = 1'b1; user_rden = 1'b1;
    tick();
    user_wren = 1'b0; user_rden = 1'b0; user_wstrb = '0;
    check("wr_rd_both", user_rd_data, 32'h0);
    scratch_m = d;
    rd(32'h04, rdv); check("wr_rd_scratch", rdv, scratch_m);

    wr(32'h14, 32'h8, 4'hF); mask_m = 32'h8;
    drive_src(8'h08); tick();
    drive_src(8'h00); tick();
    check("irq_n2", 32'(user_irq), 32'h0);
    tick();
    check("irq_n3", 32'(user_irq), 32'h1);
    rd(32'h10, rdv); check("pend_bit3", rdv, pend_m);
    wr(32'h10, 32'h8, 4'hF); pend_m = '0;
    check("irq_w1c_same", 32'(user_irq), 32'h1);
    tick();
    check("irq_w1c_next", 32'(user_irq), 32'h0);

    irq_src_i = 8'h08; tick();
    wr(32'h10, 32'h8, 4'hF);
    irq_src_i = 8'h00;
    pend_m = 32'h8;
    rd(32'h10, rdv); check("set_wins", rdv, pend_m);
    wr(32'h10, 32'hFFFFFFFF, 4'hF); pend_m = '0;

    for (int r = 0; r < 3; r++) begin
      d = $urandom; s = 4'($urandom_range(0, 15));
      wr(32'h14, d, s);
      mask_m = ((mask_m & ~bm(s)) | (d & bm(s))) & VALID;
      for (int c = 0; c < 24; c++) begin
        drive_src(IRQ_W'($urandom));
        tick();
      end
      tick(); tick(); tick();
      rd(32'h10, rdv); check("rand_pend", rdv, pend_m);
      rd(32'h14, rdv); check("rand_mask", rdv, mask_m);
      check("rand_irq", 32'(user_irq), 32'(|(pend_m & mask_m)));
      d = $urandom; s = 4'($urandom_range(0, 15));
      wr(32'h10, d, s);
      pend_m = pend_m & ~(d & bm(s));
      tick();
      rd(32'h10, rdv); check("rand_w1c", rdv, pend_m);
      check("rand_w1c_irq", 32'(user_irq), 32'(|(pend_m & mask_m)));
    end

    drive_src(8'h00); tick(); tick(); tick();
    wr(32'h14, 32'hFFFFFFFF, 4'hF); mask_m = VALID;
    rd(32'h14, rdv); check("mask_upper", rdv, VALID);
    wr(32'h10, 32'hFFFFFFFF, 4'hF); pend_m = '0;
    tick();
    rd(32'h10, rdv); check("pend_clear", rdv, 32'h0);

`ifdef XLREGBANK_EVT_FIFO_EN
    for (int i = 1; i <= 17; i++) begin
      evt_valid_i = 1'b1; evt_data_i = EVT_W'(i);
      tick();
    end
    evt_valid_i = 1'b0;
    rd(32'h1C, rdv); check("evt_stat_ovf", rdv, 32'h80000010);
    rd(32'h10, rdv); check("pend_ovf_ne", rdv, 32'hC0000000);
    check("irq_fifo", 32'(user_irq), 32'h1);
    for (int i = 1; i <= 16; i++) begin
      rd(32'h18, rdv); check("evt_drain", rdv, 32'(i));
    end
    rd(32'h18, rdv); check("evt_empty_rd", rdv, 32'h0);
    rd(32'h1C, rdv); check("evt_stat_sticky", rdv, 32'h80000000);
    wr(32'h1C, 32'h80000000, 4'b1000);
    rd(32'h1C, rdv); check("evt_stat_clr", rdv, 32'h0);
    wr(32'h10, 32'h40000000, 4'hF);
    rd(32'h10, rdv); check("pend_ovf_clr", rdv, 32'h0);

    for (int i = 0; i < 16; i++) begin
      w = EVT_W'($urandom); q.push_back(w);
      evt_valid_i = 1'b1; evt_data_i = w;
      tick();
    end
    w = EVT_W'($urandom);
    evt_data_i = w; user_addr = 32'h18; user_rden = 1'b1;
    tick();
    evt_valid_i = 1'b0; user_rden = 1'b0;
    check("full_pushpop", user_rd_data, 32'(q.pop_front()));
    q.push_back(w);
    rd(32'h1C, rdv); check("full_occ", rdv, 32'h10);
    rd(32'h10, rdv); check("full_no_ovf", rdv, 32'h80000000);
    while (q.size() > 0) begin
      rd(32'h18, rdv); check("full_drain", rdv, 32'(q.pop_front()));
    end

    w = EVT_W'($urandom);
    evt_valid_i = 1'b1; evt_data_i = w; user_addr = 32'h18; user_rden = 1'b1;
    tick();
    evt_valid_i = 1'b0; user_rden = 1'b0;
    check("empty_pushpop", user_rd_data, 32'h0);
    rd(32'h1C, rdv); check("empty_occ", rdv, 32'h1);
    rd(32'h18, rdv); check("empty_pushed", rdv, 32'(w));

    evt_valid_i = 1'b1; evt_data_i = EVT_W'($urandom);
    tick(); tick(); tick();
    evt_valid_i = 1'b0;
`else
    rd(32'h18, rdv); check("evt_data_off", rdv, 32'h0);
    rd(32'h1C, rdv); check("evt_stat_off", rdv, 32'h0);
    for (int c = 0; c < 20; c++) begin
      evt_valid_i = 1'($urandom_range(0, 1)); evt_data_i = EVT_W'($urandom);
      tick();
      check("evt_no_irq", 32'(user_irq), 32'h0);
    end
    evt_valid_i = 1'b0;
    rd(32'h10, rdv); check("pend_no_evt", rdv, 32'h0);
`endif

    wr(32'h08, 32'hFFFFFFFF, 4'hF);
    wr(32'h04, 32'h12345678, 4'hF);
    rd(32'h04, rdv);
    bus_rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", ctrl_o, 32'h0);
    check("async_rst_rd", user_rd_data, 32'h0);
    check("async_rst_irq", 32'(user_irq), 32'h0);
    pend_m = '0; prev_src = '0; mask_m = '0; scratch_m = '0;
    drive_src(8'h02);
    tick();
    bus_rst_n = 1'b1;
    tick(); tick(); tick();
    rd(32'h10, rdv); check("rst_src_high", rdv, pend_m);
    rd(32'h04, rdv); check("rst_scratch", rdv, 32'h0);
    rd(32'h1C, rdv); check("rst_evt_stat", rdv, 32'h0);
    rd(32'h00, rdv); check("rst_id", rdv, ID);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xillybus_lite_regbank.md
# xillybus_lite_regbank

Register bank and interrupt controller on the user side of the Xillybus Lite port, in the `user_clk` domain. It decodes `user_wren`/`user_rden`/`user_addr` strobes into a small map:

- ID, scratch, control and status registers
- masked edge-triggered interrupt pending register driving `user_irq`
- event FIFO that firmware drains by register reads

It sits directly downstream of the Xillybus Lite pins and feeds `ctrl_o` into the MZTIO fabric logic.

## Interface
- `ID_VALUE`, 32'h4D5A5449: constant returned at offset 0x00
- `IRQ_W`, 8: number of edge-triggered interrupt sources (1..30)
- `FIFO_AW`, 4: event FIFO address width (depth 2**FIFO_AW)
- `EVT_W`, 16: event word width (≤32)
- `user_clk`  in  1  sole clock
- `bus_rst_n`  in  1  asynchronous active-low reset
- `user_wren`  in  1  write strobe, one cycle per access
- `user_wstrb`  in  4  byte enables for writes
- `user_rden`  in  1  read strobe, one cycle per access
- `user_addr`  in  32  byte address; only [6:2] decoded
- `user_wr_data`  in  32  write data
- `user_rd_data`  out  32  read data, registered
- `user_irq`  out  1  level interrupt to host, registered
- `ctrl_o`  out  32  CTRL register contents
- `status_i`  in  32  fabric status, sampled every cycle
- `irq_src_i`  in  IRQ_W  interrupt sources, rising-edge detected
- `evt_valid_i`  in  1  push strobe for event FIFO
- `evt_data_i`  in  EVT_W  event word

## Operation
Register map (word offsets; unmapped offsets read 0, writes ignored):
- 0x00 ID: RO, returns `ID_VALUE`
- 0x04 SCRATCH: RW, byte-strobed
- 0x08 CTRL: RW, byte-strobed, drives `ctrl_o`
- 0x0C STATUS: RO, `status_i` registered once
- 0x10 IRQ_PEND: W1C, byte-strobed
  - [IRQ_W-1:0] source edges
  - [30] FIFO overflow
  - [31] FIFO non-empty (level, not W1C, read-only)
- 0x14 IRQ_MASK: RW, byte-strobed, same bit layout
- 0x18 EVT_DATA: RO; read returns FIFO head zero-extended and pops it; read when empty returns 0, no pop
- 0x1C EVT_STAT: [FIFO_AW:0] occupancy, [31] sticky overflow; write with wr_data[31]=1 and wstrb[3]=1 clears [31]

Interrupt sources:
- each `irq_src_i` is registered; 0→1 between consecutive cycles sets the pending bit
- source register resets to 0, so a source high at reset release sets pending once
- set and W1C on the same bit in the same cycle: set wins

`user_irq` = |(IRQ_PEND & IRQ_MASK).

Event FIFO push:
- push on `evt_valid_i` when not full
- push when full with no same-cycle pop: word dropped, EVT_STAT[31] and IRQ_PEND[30] set
- push and pop in the same cycle at full: both occur, occupancy unchanged, no overflow
- push and pop in the same cycle at empty: push only

Access rules:
- `user_wren` and `user_rden` are never asserted together; if they are, write takes effect and the read returns 0 with no pop
- bits above IRQ_W in PEND/MASK (other than 30/31) read 0

## Timing
- Read latency: `user_rd_data` valid exactly 1 cycle after `user_rden`; holds until next read.
- Writes: register updates on the `user_wren` edge; visible to a read issued the next cycle.
- `ctrl_o` reflects a write 1 cycle after `user_wren`.
- `user_irq` is 1 cycle after the PEND/MASK change that causes it.
- Edge to pending: `irq_src_i` rising at cycle n sets PEND at n+2 (input register plus edge compare); `user_irq` rises at n+3.
- STATUS reads reflect `status_i` sampled 2 cycles before `user_rd_data`.
- Reset values of all outputs and registers are 0: `user_rd_data`, `user_irq`, `ctrl_o`, SCRATCH, PEND, MASK, FIFO empty, overflow clear.
- Reset asserted mid-operation clears everything immediately, including FIFO contents.

## Configuration
- `XLREGBANK_EVT_FIFO_EN` defined: event FIFO, EVT_DATA, EVT_STAT and PEND bits 30/31 are present.
- Not defined:
  - FIFO logic is absent
  - 0x18/0x1C read 0
  - PEND[31:30] and MASK[31:30] read 0
  - `evt_valid_i` and `evt_data_i` are ignored

## Structure
- Shared package `xlregbank_pkg` holds:
  - register offset localparams
  - PEND bit indices (`PEND_OVF`=30, `PEND_NE`=31)
  - `ID_VALUE` default
- One sub-module, `xlregbank_evt_fifo`: synchronous single-clock FIFO with push/pop, full/empty, occupancy, and an overflow pulse output; instantiated only under `XLREGBANK_EVT_FIFO_EN`.

## Test plan
- Reset, then read 0x00 → `user_rd_data`=32'h4D5A5449 on the cycle after `user_rden`; all outputs 0 beforehand.
- Write 0x08 with data 32'hA5A5A5A5 and wstrb=4'b0101 → `ctrl_o`=32'h00A500A5 next cycle; readback matches.
- Pulse `irq_src_i[3]` with MASK=32'h8 → `user_irq` rises 3 cycles later; W1C write of 32'h8 to 0x10 → `user_irq`=0 a cycle after PEND clears; same-cycle new edge plus W1C → bit stays set.
- Push 16 events 0x0001..0x0010, push a 17th → EVT_STAT=32'h80000010, PEND[30]=1; 16 reads of 0x18 return 0x1..0x10 in order, 17th read returns 0.
- At full, push and pop in the same cycle → occupancy stays 16, no overflow, popped word is the head.
- Macro undefined → 0x18/0x1C read 0 and `evt_valid_i` activity never raises `user_irq` with MASK=32'hFFFFFFFF.
